// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command bytes and DDRAM row addressing for lcd_text_ctrl.
package lcd_pkg;

  typedef enum logic [3:0] {
    PWR_WAIT, WAKE, FUNC_SET, ENTRY_MODE, DISP_ON, CLEAR, HOME_ADDR, IDLE, WRITE, REPOS
  } lcd_state_e;

  typedef enum logic [1:0] {
    TX_IDLE, TX_SETUP, TX_STROBE, TX_WAIT
  } tx_phase_e;

  localparam logic [7:0] CMD_WAKE       = 8'h30;
  localparam logic [7:0] CMD_FUNC_8B2L  = 8'h38;
  localparam logic [7:0] CMD_FUNC_8B1L  = 8'h30;
  localparam logic [7:0] CMD_ENTRY      = 8'h06;
  localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_HOME       = 8'h02;
  localparam logic [7:0] CMD_SETADDR    = 8'h80;

  // Rows 2/3 of 4-line panels continue lines 0/1 of DDRAM after COLS characters.
  function automatic logic [7:0] row_base(input logic [1:0] row, input logic [7:0] cols);
    logic [7:0] base;
    case (row)
      2'd0:    base = 8'h00;
      2'd1:    base = 8'h40;
      2'd2:    base = cols;
      default: base = 8'h40 + cols;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// Sends one byte on the LCD bus: 2-cycle setup, E_PULSE_CYC strobe, then the post-byte wait.
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int E_PULSE_CYC = 12,
  parameter int CW          = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  input  logic          i_rs,
  input  logic [7:0]    i_byte,
  input  logic [CW-1:0] i_wait_cyc,
  output logic          o_done,
  output logic          o_busy,
  output logic [7:0]    o_lcd_db,
  output logic          o_lcd_e,
  output logic          o_lcd_rs
);

  tx_phase_e     r_phase;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_wait;
  logic [7:0]    r_db;
  logic          r_rs;
  logic          r_e;

  // The start cycle in the caller counts as the first cycle of the byte time,
  // so the final wait cycle is flagged one count early.
  assign o_done   = (r_phase == TX_WAIT) && (r_cnt == r_wait - CW'(2));
  assign o_busy   = (r_phase != TX_IDLE);
  assign o_lcd_db = r_db;
  assign o_lcd_e  = r_e;
  assign o_lcd_rs = r_rs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= TX_IDLE;
      r_cnt   <= '0;
      r_wait  <= '0;
      r_db    <= '0;
      r_rs    <= 1'b0;
      r_e     <= 1'b0;
    end else begin
      case (r_phase)
        TX_IDLE: begin
          if (i_start) begin
            r_db    <= i_byte;
            r_rs    <= i_rs;
            r_wait  <= i_wait_cyc;
            r_cnt   <= '0;
            r_phase <= TX_SETUP;
          end
        end
        TX_SETUP: begin
          if (r_cnt == CW'(1)) begin
            r_cnt   <= '0;
            r_e     <= 1'b1;
            r_phase <= TX_STROBE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        TX_STROBE: begin
          if (r_cnt == CW'(E_PULSE_CYC - 1)) begin
            r_cnt   <= '0;
            r_e     <= 1'b0;
            r_phase <= TX_WAIT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          if (o_done) begin
            r_cnt   <= '0;
            r_db    <= '0;
            r_rs    <= 1'b0;
            r_phase <= TX_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/lcd_text_ctrl.sv
// HD44780 text controller: power-on init, byte handshake, cursor tracking with auto line wrap.
// Optional LCD_NEWLINE_EN: character 0x0A moves to the next row instead of being printed.
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int ROWS           = 2,
  parameter int COLS           = 16,
  parameter int POWERUP_CYC    = 750000,
  parameter int WAKE_CYC       = 205000,
  parameter int E_PULSE_CYC    = 12,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_cmd,
  output logic       init_done,
  output logic [7:0] lcd_db,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw
);

  localparam int MAXW = (POWERUP_CYC > CLEAR_WAIT_CYC) ? POWERUP_CYC : CLEAR_WAIT_CYC;
  localparam int CW   = $clog2(MAXW + 1);

  lcd_state_e    r_state;
  lcd_state_e    w_state_next;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_wake_n;
  logic          r_init_done;
  logic [1:0]    r_row;
  logic [5:0]    r_col;
  logic [7:0]    r_byte;
  logic          r_cmd;
  logic          r_wrap;

  logic          w_accept;
  logic          w_newline;
  logic [1:0]    w_row_inc;
  logic          w_tx_start;
  logic          w_tx_rs;
  logic [7:0]    w_tx_byte;
  logic [CW-1:0] w_tx_wait;
  logic          w_tx_done;
  logic          w_tx_busy;

  assign in_ready  = (r_state == IDLE);
  assign init_done = r_init_done;
  assign lcd_rw    = 1'b0;
  assign w_accept  = in_valid && in_ready;
  assign w_row_inc = (r_row == 2'(ROWS - 1)) ? 2'd0 : r_row + 2'd1;

`ifdef LCD_NEWLINE_EN
  assign w_newline = !in_cmd && (in_data == 8'h0A);
`else
  assign w_newline = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_tx_start   = 1'b0;
    w_tx_rs      = 1'b0;
    w_tx_byte    = 8'h00;
    w_tx_wait    = CW'(CMD_WAIT_CYC);
    case (r_state)
      PWR_WAIT: begin
        if (r_cnt == CW'(POWERUP_CYC - 1)) w_state_next = WAKE;
      end
      WAKE: begin
        w_tx_start = !w_tx_busy;
        w_tx_byte  = CMD_WAKE;
        w_tx_wait  = CW'(WAKE_CYC);
        if (w_tx_done && r_wake_n == 2'd2) w_state_next = FUNC_SET;
      end
      FUNC_SET: begin
        w_tx_start = !w_tx_busy;
        w_tx_byte  = (ROWS > 1) ? CMD_FUNC_8B2L : CMD_FUNC_8B1L;
        if (w_tx_done) w_state_next = ENTRY_MODE;
      end
      ENTRY_MODE: begin
        w_tx_start = !w_tx_busy;
        w_tx_byte  = CMD_ENTRY;
        if (w_tx_done) w_state_next = DISP_ON;
      end
      DISP_ON: begin
        w_tx_start = !w_tx_busy;
        w_tx_byte  = CMD_DISP_ON;
        if (w_tx_done) w_state_next = CLEAR;
      end
      CLEAR: begin
        w_tx_start = !w_tx_busy;
        w_tx_byte  = CMD_CLEAR;
        w_tx_wait  = CW'(CLEAR_WAIT_CYC);
        if (w_tx_done) w_state_next = HOME_ADDR;
      end
      HOME_ADDR: begin
        w_tx_start = !w_tx_busy;
        w_tx_byte  = CMD_SETADDR;
        if (w_tx_done) w_state_next = IDLE;
      end
      IDLE: begin
        if (w_accept) w_state_next = w_newline ? REPOS : WRITE;
      end
      WRITE: begin
        w_tx_start = !w_tx_busy;
        w_tx_rs    = !r_cmd;
        w_tx_byte  = r_byte;
        if (r_cmd && (r_byte == CMD_CLEAR || r_byte == CMD_HOME))
          w_tx_wait = CW'(CLEAR_WAIT_CYC);
        if (w_tx_done) w_state_next = r_wrap ? REPOS : IDLE;
      end
      REPOS: begin
        w_tx_start = !w_tx_busy;
        w_tx_byte  = CMD_SETADDR | row_base(r_row, 8'(COLS));
        if (w_tx_done) w_state_next = IDLE;
      end
      default: w_state_next = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= PWR_WAIT;
      r_cnt       <= '0;
      r_wake_n    <= '0;
      r_init_done <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
      r_byte      <= '0;
      r_cmd       <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == PWR_WAIT) r_cnt <= r_cnt + CW'(1);
      if (r_state == WAKE && w_tx_done) r_wake_n <= r_wake_n + 2'd1;
      if (r_state == HOME_ADDR && w_tx_done) r_init_done <= 1'b1;
      if (w_accept) begin
        r_byte <= in_data;
        r_cmd  <= in_cmd;
        r_wrap <= 1'b0;
        if (in_cmd) begin
          // Set-address commands (bit 7) leave the cursor alone; the sender owns coherence.
          if (in_data == CMD_CLEAR || in_data == CMD_HOME) begin
            r_row <= '0;
            r_col <= '0;
          end
        end else if (w_newline || r_col == 6'(COLS - 1)) begin
          r_col  <= '0;
          r_row  <= w_row_inc;
          r_wrap <= 1'b1;
        end else begin
          r_col <= r_col + 6'd1;
        end
      end
    end
  end

  lcd_byte_tx #(
    .E_PULSE_CYC (E_PULSE_CYC),
    .CW          (CW)
  ) u_tx (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_tx_start),
    .i_rs       (w_tx_rs),
    .i_byte     (w_tx_byte),
    .i_wait_cyc (w_tx_wait),
    .o_done     (w_tx_done),
    .o_busy     (w_tx_busy),
    .o_lcd_db   (lcd_db),
    .o_lcd_e    (lcd_e),
    .o_lcd_rs   (lcd_rs)
  );

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Directed bench for lcd_text_ctrl with a byte scoreboard fed by stimulus and drained on lcd_e pulses.
module tb_lcd_text_ctrl;

  localparam int ROWS = 2;
  localparam int COLS = 16;
  localparam int PWR  = 50;
  localparam int WK   = 20;
  localparam int EP   = 3;
  localparam int CWT  = 10;
  localparam int CLR  = 30;
  localparam int BYTE_T  = 2 + EP + CWT;
  localparam int CLR_T   = 2 + EP + CLR;
  localparam int INIT_T  = PWR + 3 * (2 + EP + WK) + 4 * BYTE_T + CLR_T;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_cmd;
  logic       init_done;
  logic [7:0] lcd_db;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;

  int tests = 0;
  int fails = 0;
  logic [8:0] sb[$];
  bit  mon_en = 1'b0;
  logic e_prev = 1'b0;
  int  e_w = 0;
  int  mcol = 0;
  int  mrow = 0;

  always #5 clk = ~clk;

  lcd_text_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .POWERUP_CYC(PWR), .WAKE_CYC(WK),
    .E_PULSE_CYC(EP), .CMD_WAIT_CYC(CWT), .CLEAR_WAIT_CYC(CLR)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_cmd(in_cmd), .init_done(init_done),
    .lcd_db(lcd_db), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard drain: one entry per lcd_e rising edge, plus a strobe-width check.
  always @(negedge clk) begin
    if (mon_en) begin
      if (lcd_e && !e_prev) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check("sb_byte", {23'd0, lcd_rs, lcd_db}, {23'd0, sb.pop_front()});
        e_w = 1;
      end else if (lcd_e) begin
        e_w++;
      end else if (e_prev) begin
        check("e_width", e_w, EP);
      end
    end
    e_prev = lcd_e;
  end

  function automatic logic [7:0] base_of(input int r);
    logic [7:0] b;
    case (r)
      0: b = 8'h00;
      1: b = 8'h40;
      2: b = 8'(COLS);
      default: b = 8'h40 + 8'(COLS);
    endcase
    return b;
  endfunction

  task automatic push_init();
    sb.push_back({1'b0, 8'h30});
    sb.push_back({1'b0, 8'h30});
    sb.push_back({1'b0, 8'h30});
    sb.push_back({1'b0, 8'h38});
    sb.push_back({1'b0, 8'h06});
    sb.push_back({1'b0, 8'h0C});
    sb.push_back({1'b0, 8'h01});
    sb.push_back({1'b0, 8'h80});
  endtask

  task automatic wait_init();
    int cyc = 0;
    while (!init_done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("init_cycles", cyc, INIT_T);
    check("init_ready", 32'(in_ready), 32'd1);
  endtask

  // Offer one byte, then check first-byte bus values, strobe timing and in_ready latency.
  task automatic send(input logic [7:0] d, input logic c, input logic [8:0] first, input int exp_lat);
    int j = 0;
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_cmd = c;
    while (!in_ready && j < 2000) begin
      @(negedge clk);
      j++;
    end
    check("accept_bound", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bus_n1", {23'd0, lcd_rs, lcd_db}, {23'd0, first});
    @(posedge clk); #1;
    check("e_low_n2", 32'(lcd_e), 32'd0);
    @(posedge clk); #1;
    check("e_high_n3", 32'(lcd_e), 32'd1);
    lat = 3;
    while (!in_ready && lat < 500) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ready_latency", lat, exp_lat);
    check("idle_bus", {23'd0, lcd_rs, lcd_db}, 32'd0);
    $display("[TB] tx data=0x%02h cmd=%0d latency=%0d cursor=(%0d,%0d)", d, c, lat, mrow, mcol);
  endtask

  task automatic send_char(input logic [7:0] ch);
    bit wrap;
    sb.push_back({1'b1, ch});
    mcol++;
    wrap = (mcol == COLS);
    if (wrap) begin
      mcol = 0;
      mrow = (mrow + 1) % ROWS;
      sb.push_back({1'b0, 8'h80 | base_of(mrow)});
    end
    send(ch, 1'b0, {1'b1, ch}, wrap ? 2 * BYTE_T : BYTE_T);
  endtask

  task automatic send_cmd(input logic [7:0] cb);
    bit slow;
    slow = (cb == 8'h01) || (cb == 8'h02);
    sb.push_back({1'b0, cb});
    if (slow) begin
      mcol = 0;
      mrow = 0;
    end
    send(cb, 1'b1, {1'b0, cb}, slow ? CLR_T : BYTE_T);
  endtask

  initial begin
    int k;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_cmd = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_db", 32'(lcd_db), 32'd0);
    check("rst_e", 32'(lcd_e), 32'd0);
    check("rst_rs", 32'(lcd_rs), 32'd0);
    check("rst_rw", 32'(lcd_rw), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);

    push_init();
    mon_en = 1'b1;
    reset = 1'b0;
    wait_init();
    check("init_sb_empty", sb.size(), 0);

    send_char(8'h41);
    for (int i = 0; i < 15; i++) send_char(8'h42 + 8'(i));
    send_char(8'h61);
    for (int i = 0; i < 15; i++) send_char(8'h62 + 8'(i));
    check("wrap_row0", mrow, 0);

    send_cmd(8'h01);
    send_char(8'h42);
    send_cmd(8'h0E);
    send_cmd(8'hC5);
    send_cmd(8'h02);
    send_char(8'h43);

`ifdef LCD_NEWLINE_EN
    mcol = 0;
    mrow = (mrow + 1) % ROWS;
    sb.push_back({1'b0, 8'h80 | base_of(mrow)});
    send(8'h0A, 1'b0, {1'b0, 8'hC0}, BYTE_T);
`else
    send_char(8'h0A);
`endif
    send_char(8'h44);
    check("sb_drained", sb.size(), 0);

    // Reset in the middle of a strobe.
    mon_en = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h55; in_cmd = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!lcd_e && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("strobe_seen", 32'(lcd_e), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_e", 32'(lcd_e), 32'd0);
    check("midrst_db", 32'(lcd_db), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    check("midrst_init_done", 32'(init_done), 32'd0);
    sb.delete();
    mcol = 0; mrow = 0;
    @(negedge clk);
    push_init();
    mon_en = 1'b1;
    reset = 1'b0;
    wait_init();
    send_char(8'h5A);
    check("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
